// File: rtl/bus_decoder_n_if.sv
// rtl/bus_decoder_n_if.sv - pipelined Wishbone bundle shared by the master side and the N slave ports
//
// Purpose: one Wishbone (pipelined) link with N strobe/response lanes.
//   N = 1        : a single master link.
//   N = NSLAVES  : the fan-out towards the slaves. Address, write data, we and sel are broadcast.
//                  cyc/stb/ack/err/stall carry one bit per slave.
//                  data_s2m carries 32 bits per slave, with slave i at [32*i +: 32].
// Modports:
//   master : drives addr/data_m2s/we/sel/cyc/stb, receives data_s2m/ack/err/stall
//   slave  : the mirror image
interface bus_decoder_n_if #(
    parameter int N = 1
);
    logic [29:0]     addr;
    logic [31:0]     data_m2s;
    logic            we;
    logic [3:0]      sel;
    logic [N-1:0]    cyc;
    logic [N-1:0]    stb;
    logic [N*32-1:0] data_s2m;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [N-1:0]    stall;

    modport master (
        output addr, data_m2s, we, sel, cyc, stb,
        input  data_s2m, ack, err, stall
    );

    modport slave (
        input  addr, data_m2s, we, sel, cyc, stb,
        output data_s2m, ack, err, stall
    );
endinterface

// File: rtl/bus_decoder_n.sv
// rtl/bus_decoder_n.sv - 1-master / N-slave pipelined Wishbone address decoder and response router
//
// Purpose: decodes the master word address against per-slave base/width windows. The lowest
//   matching index wins. The decoder strobes the matching slave and counts outstanding requests.
//   While requests are outstanding it locks the response path to the owning slave. It signals
//   ERR in three cases: an unmapped access, a response timeout (Wishbone abort), or an error
//   returned by the owning slave.
// Ports:
//   clk : bus clock
//   rst : synchronous active-high reset. While it is high, m_cyc is ignored.
//   m   : master link (N=1). This block acts as the slave on this link.
//   s   : slave fan-out (N=NSLAVES). This block acts as the master on this link.
//         Address/data/we/sel are broadcast; cyc/stb go to one slave only.
module bus_decoder_n #(
    parameter int                      NSLAVES         = 4,
    parameter logic [NSLAVES*30-1:0]   BASE_ADDR       = {NSLAVES{30'h0}},
    parameter logic [NSLAVES*32-1:0]   ADDR_WIDTH      = {NSLAVES{32'd8}},
    parameter int                      MAX_OUTSTANDING = 4,
    parameter int                      TIMEOUT         = 255
) (
    input  logic           clk,
    input  logic           rst,
    bus_decoder_n_if.slave  m,
    bus_decoder_n_if.master s
);
    localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT);

    // Registered state
    logic [CW-1:0] cnt_q, cnt_d;   // accepted but unanswered requests
    logic [TW-1:0] tmr_q, tmr_d;   // busy cycles without a response
    logic [IW-1:0] tgt_q, tgt_d;   // slave that owns the response path
    logic          uerr_q, uerr_d; // unmapped access issued last cycle
    logic          to_q, to_d;     // timeout abort cycle

    // Address decode
    logic [NSLAVES-1:0] hit;
    logic               dec_hit;
    logic [IW-1:0]      dec_idx;

    for (genvar g = 0; g < NSLAVES; g++) begin : g_hit
        localparam int          AW   = int'(ADDR_WIDTH[32*g +: 32]);
        localparam logic [29:0] BASE = BASE_ADDR[30*g +: 30];
        assign hit[g] = ((m.addr >> AW) == (BASE >> AW));
    end

    // Scan downwards so that the lowest matching index is the one left in dec_idx.
    always_comb begin
        dec_idx = '0;
        dec_hit = 1'b0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_idx = IW'(i);
                dec_hit = 1'b1;
            end
        end
    end

    // Control
    logic          busy;
    logic          full;
    logic [IW-1:0] tgt_cur;
    logic          int_block;
    logic          s_stall_dec;
    logic          tgt_ack;
    logic          tgt_err;
    logic [31:0]   rdata;
    logic          stall_w;
    logic          issue;
    logic          resp;
    logic          fire;

    assign busy    = (cnt_q != '0);
    assign full    = (cnt_q == CW'(MAX_OUTSTANDING));
    assign tgt_cur = busy ? tgt_q : dec_idx;

    // These stall terms depend only on registered state and on the master request. s_stb is
    // gated by these terms alone. The slave's own stall therefore reaches m_stall but never
    // loops back into s_stb. A slave that sees stb while it is stalling simply does not
    // accept the request, so master and slave still agree.
    assign int_block = to_q | uerr_q | full | (busy & (!dec_hit | (dec_idx != tgt_q)));

    always_comb begin
        s_stall_dec = 1'b0;
        tgt_ack     = 1'b0;
        tgt_err     = 1'b0;
        rdata       = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (dec_idx == IW'(i)) begin
                s_stall_dec = s.stall[i];
            end
            if (tgt_cur == IW'(i)) begin
                tgt_ack = s.ack[i];
                tgt_err = s.err[i];
                rdata   = s.data_s2m[32*i +: 32];
            end
        end
    end

    assign stall_w = rst | int_block | (dec_hit & s_stall_dec);
    assign issue   = m.cyc[0] & m.stb[0] & !stall_w;

    // Responses are accepted only from the owning slave while requests are outstanding.
    // Any other response is a stray and is dropped.
    assign resp    = busy & (tgt_ack | tgt_err);
    assign fire    = busy & !resp & (tmr_q == TW'(TIMEOUT - 1));

    // Master-side outputs
    assign m.stall    = stall_w;
    assign m.ack      = !rst & busy & tgt_ack;
    assign m.err      = !rst & ((busy & tgt_err) | uerr_q | to_q);
    assign m.data_s2m = rdata;

    // Slave-side outputs
    assign s.addr     = m.addr;
    assign s.data_m2s = m.data_m2s;
    assign s.we       = m.we;
    assign s.sel      = m.sel;

    // While the response path is locked, cyc stays on the owner.
    // In the abort cycle all cyc lines drop.
    always_comb begin
        for (int i = 0; i < NSLAVES; i++) begin
            s.cyc[i] = !rst & !to_q & m.cyc[0] &
                       (busy ? (tgt_q == IW'(i)) : (dec_hit & (dec_idx == IW'(i))));
            s.stb[i] = !rst & m.cyc[0] & m.stb[0] & dec_hit & (dec_idx == IW'(i)) & !int_block;
        end
    end

    // Next state
    always_comb begin
        cnt_d  = cnt_q;
        tmr_d  = tmr_q;
        tgt_d  = tgt_q;
        uerr_d = 1'b0;
        to_d   = 1'b0;
        if (!m.cyc[0]) begin
            // The master abandoned the cycle. Drop everything that is still pending.
            cnt_d = '0;
            tmr_d = '0;
        end else if (fire) begin
            cnt_d = '0;
            tmr_d = '0;
            to_d  = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(issue & dec_hit) - CW'(resp);
            tmr_d  = (busy & !resp) ? (tmr_q + TW'(1)) : '0;
            uerr_d = issue & !dec_hit;
            if (!busy && dec_hit) begin
                tgt_d = dec_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tmr_q  <= '0;
            tgt_q  <= '0;
            uerr_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tmr_q  <= tmr_d;
            tgt_q  <= tgt_d;
            uerr_q <= uerr_d;
            to_q   <= to_d;
        end
    end
endmodule

// File: tb/tb_bus_decoder_n.sv
// tb/tb_bus_decoder_n.sv - self-checking bench for bus_decoder_n: directed scenarios then random traffic
module tb_bus_decoder_n;
    localparam int NS   = 4;
    localparam int MAXO = 4;
    localparam int TMO  = 16;
    localparam logic [NS*30-1:0] BASES = {30'h0, 30'h100, 30'h300, 30'h0};
    localparam logic [NS*32-1:0] AWS   = {32'd12, 32'd8, 32'd8, 32'd8};

    // Reference copy of the address map, indexed by slave number
    int base_tab [NS] = '{0, 'h300, 'h100, 0};
    int aw_tab   [NS] = '{8, 8, 8, 12};

    logic clk;
    logic rst;

    bus_decoder_n_if #(.N(1))  m_if ();
    bus_decoder_n_if #(.N(NS)) s_if ();

    bus_decoder_n #(
        .NSLAVES(NS), .BASE_ADDR(BASES), .ADDR_WIDTH(AWS),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m(m_if), .s(s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;
    int n_fail;

    // Reference model state
    int mo_outst;
    int mo_owner;
    int mo_quiet;
    bit mo_uerr;
    bit mo_abort;
    int e_dec;
    bit e_issue;
    bit e_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the lowest-index slave whose window contains the address, or -1 if none does.
    function automatic int mdec(input logic [29:0] a);
        longint la;
        longint span;
        int r;
        la = longint'(a);
        r  = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            span = longint'(1) << aw_tab[i];
            if (la / span == longint'(base_tab[i]) / span) r = i;
        end
        return r;
    endfunction

    task automatic sample();
        logic [NS-1:0] ecyc;
        logic [NS-1:0] estb;
        bit blocked;
        bit estall;
        bit eack;
        bit eerr;
        @(negedge clk);
        chk("bcast_addr", 64'(s_if.addr), 64'(m_if.addr));
        if (rst) begin
            chk("rst_s_cyc", 64'(s_if.cyc), 64'(0));
            chk("rst_s_stb", 64'(s_if.stb), 64'(0));
            chk("rst_m_ack", 64'(m_if.ack), 64'(0));
            chk("rst_m_err", 64'(m_if.err), 64'(0));
            e_issue = 1'b0;
            e_resp  = 1'b0;
            return;
        end
        e_dec   = mdec(m_if.addr);
        blocked = mo_abort || mo_uerr || (mo_outst == MAXO) || (mo_outst > 0 && e_dec != mo_owner);
        estall  = blocked || (e_dec >= 0 && s_if.stall[e_dec] == 1'b1);
        e_issue = m_if.cyc[0] && m_if.stb[0] && !estall;
        estb = '0;
        if (m_if.cyc[0] && m_if.stb[0] && e_dec >= 0 && !blocked) estb[e_dec] = 1'b1;
        ecyc = '0;
        if (!mo_abort && m_if.cyc[0]) begin
            if (mo_outst > 0) ecyc[mo_owner] = 1'b1;
            else if (e_dec >= 0) ecyc[e_dec] = 1'b1;
        end
        eack   = (mo_outst > 0) && s_if.ack[mo_owner];
        eerr   = ((mo_outst > 0) && s_if.err[mo_owner]) || mo_uerr || mo_abort;
        e_resp = (mo_outst > 0) && (s_if.ack[mo_owner] || s_if.err[mo_owner]);
        chk("m_stall", 64'(m_if.stall), 64'(estall));
        chk("s_stb",   64'(s_if.stb),   64'(estb));
        chk("s_cyc",   64'(s_if.cyc),   64'(ecyc));
        chk("m_ack",   64'(m_if.ack),   64'(eack));
        chk("m_err",   64'(m_if.err),   64'(eerr));
        if (eack) chk("m_data", 64'(m_if.data_s2m), 64'(s_if.data_s2m[32*mo_owner +: 32]));
    endtask

    task automatic advance();
        bit abort_next;
        @(posedge clk);
        if (rst || !m_if.cyc[0]) begin
            mo_outst = 0;
            mo_quiet = 0;
            mo_uerr  = 1'b0;
            mo_abort = 1'b0;
        end else begin
            abort_next = (mo_outst > 0) && !e_resp && (mo_quiet == TMO - 1);
            if (abort_next) begin
                mo_outst = 0;
                mo_quiet = 0;
            end else begin
                mo_quiet = (mo_outst > 0 && !e_resp) ? mo_quiet + 1 : 0;
                if (e_issue && e_dec >= 0) begin
                    if (mo_outst == 0) mo_owner = e_dec;
                    mo_outst++;
                end
                if (e_resp) mo_outst--;
            end
            mo_uerr  = !abort_next && e_issue && (e_dec < 0);
            mo_abort = abort_next;
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drive(input bit cyc, input bit stb, input logic [29:0] addr);
        m_if.cyc      = cyc;
        m_if.stb      = stb;
        m_if.addr     = addr;
        m_if.we       = 1'($urandom);
        m_if.sel      = 4'($urandom);
        m_if.data_m2s = $urandom;
    endtask

    int err_at;
    logic [29:0] addr_pick [11] = '{30'h005, 30'h0FF, 30'h100, 30'h1AB, 30'h300, 30'h3FE,
                                    30'h400, 30'hFFF, 30'h1000, 30'h3FFF_0000, 30'h0};

    initial begin
        n_total  = 0;
        n_pass   = 0;
        n_fail   = 0;
        mo_outst = 0;
        mo_owner = 0;
        mo_quiet = 0;
        mo_uerr  = 1'b0;
        mo_abort = 1'b0;
        e_dec    = -1;
        e_issue  = 1'b0;
        e_resp   = 1'b0;
        s_if.ack      = '0;
        s_if.err      = '0;
        s_if.stall    = '0;
        s_if.data_s2m = '0;

        // Reset, with a request presented so that m_cyc must be ignored
        rst = 1'b1;
        drive(1, 1, 30'h105);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 30'h0);
        tick();

        // Single read from slave 2
        drive(1, 1, 30'h105);
        sample();
        chk("t1_s_stb", 64'(s_if.stb), 64'(4'b0100));
        chk("t1_stall", 64'(m_if.stall), 64'(0));
        advance();
        drive(1, 0, 30'h105);
        s_if.ack = 4'b0100;
        s_if.data_s2m[64 +: 32] = 32'hDEADBEEF;
        sample();
        chk("t1_ack",  64'(m_if.ack), 64'(1));
        chk("t1_data", 64'(m_if.data_s2m), 64'(32'hDEADBEEF));
        advance();
        s_if.ack = '0;
        sample();
        chk("t1_cnt", 64'(dut.cnt_q), 64'(0));
        advance();

        // Fill slave 1 to the outstanding limit
        drive(1, 1, 30'h305);
        for (int k = 0; k < MAXO; k++) begin
            sample();
            chk("t2_issue_stall", 64'(m_if.stall), 64'(0));
            chk("t2_issue_stb", 64'(s_if.stb), 64'(4'b0010));
            advance();
        end
        sample();
        chk("t2_full_stall", 64'(m_if.stall), 64'(1));
        chk("t2_full_cnt", 64'(dut.cnt_q), 64'(MAXO));
        advance();
        s_if.ack = 4'b0010;
        sample();
        chk("t2_full_ack_stall", 64'(m_if.stall), 64'(1));
        advance();
        sample();
        chk("t2_ack_issue_stall", 64'(m_if.stall), 64'(0));
        advance();
        s_if.ack = '0;
        sample();
        chk("t2_cnt_kept", 64'(dut.cnt_q), 64'(MAXO - 1));
        advance();
        drive(1, 0, 30'h305);
        sample();
        chk("t2_cnt_full_again", 64'(dut.cnt_q), 64'(MAXO));
        advance();
        s_if.ack = 4'b0010;
        for (int k = 0; k < MAXO; k++) tick();
        s_if.ack = '0;
        sample();
        chk("t2_drained", 64'(dut.cnt_q), 64'(0));
        advance();

        // Request to another slave while slave 0 still owes a response
        drive(1, 1, 30'h010);
        sample();
        chk("t3_s0_stb", 64'(s_if.stb), 64'(4'b0001));
        advance();
        drive(1, 1, 30'h800);
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("t3_blocked_stall", 64'(m_if.stall), 64'(1));
            chk("t3_blocked_stb", 64'(s_if.stb), 64'(0));
            advance();
        end
        s_if.ack = 4'b0001;
        sample();
        chk("t3_ack0", 64'(m_if.ack), 64'(1));
        chk("t3_still_stall", 64'(m_if.stall), 64'(1));
        advance();
        s_if.ack = '0;
        sample();
        chk("t3_s3_stb", 64'(s_if.stb), 64'(4'b1000));
        chk("t3_s3_go", 64'(m_if.stall), 64'(0));
        advance();
        drive(1, 0, 30'h800);
        s_if.ack = 4'b1000;
        sample();
        chk("t3_ack3", 64'(m_if.ack), 64'(1));
        advance();
        s_if.ack = '0;

        // Unmapped access
        drive(1, 1, 30'h3FFF_0000);
        sample();
        chk("t4_no_stb", 64'(s_if.stb), 64'(0));
        chk("t4_no_stall", 64'(m_if.stall), 64'(0));
        chk("t4_no_err_yet", 64'(m_if.err), 64'(0));
        advance();
        drive(1, 1, 30'h020);
        sample();
        chk("t4_err", 64'(m_if.err), 64'(1));
        chk("t4_stall_once", 64'(m_if.stall), 64'(1));
        chk("t4_stb_held", 64'(s_if.stb), 64'(0));
        advance();
        sample();
        chk("t4_err_gone", 64'(m_if.err), 64'(0));
        chk("t4_next_stb", 64'(s_if.stb), 64'(4'b0001));
        advance();
        drive(1, 0, 30'h020);
        s_if.ack = 4'b0001;
        tick();
        s_if.ack = '0;

        // Response timeout
        drive(1, 1, 30'h305);
        sample();
        chk("t5_stb", 64'(s_if.stb), 64'(4'b0010));
        advance();
        drive(1, 0, 30'h305);
        err_at = -1;
        for (int k = 1; k <= 30 && err_at < 0; k++) begin
            sample();
            if (m_if.err === 1'b1) begin
                err_at = k;
                chk("t5_abort_cyc", 64'(s_if.cyc), 64'(0));
            end
            advance();
        end
        chk("t5_err_delay", 64'(err_at), 64'(TMO + 1));
        tick();
        tick();
        s_if.ack = 4'b0010;
        sample();
        chk("t5_late_ack", 64'(m_if.ack), 64'(0));
        advance();
        s_if.ack = '0;

        // Reset with three requests outstanding
        drive(1, 1, 30'h110);
        for (int k = 0; k < 3; k++) tick();
        drive(1, 0, 30'h110);
        sample();
        chk("t6_cnt3", 64'(dut.cnt_q), 64'(3));
        advance();
        rst = 1'b1;
        s_if.ack = 4'b0100;
        tick();
        sample();
        chk("t6_cnt0", 64'(dut.cnt_q), 64'(0));
        chk("t6_s_cyc", 64'(s_if.cyc), 64'(0));
        chk("t6_m_ack", 64'(m_if.ack), 64'(0));
        advance();
        rst = 1'b0;
        s_if.ack = '0;
        drive(0, 0, 30'h0);
        tick();

        // Random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(99) >= 3, $urandom_range(99) < 60,
                  ($urandom_range(10) == 10) ? 30'($urandom) : addr_pick[$urandom_range(9)]);
            for (int b = 0; b < NS; b++) begin
                s_if.ack[b]   = ($urandom_range(99) < 30);
                s_if.err[b]   = ($urandom_range(99) < 3);
                s_if.stall[b] = ($urandom_range(99) < 20);
                s_if.data_s2m[32*b +: 32] = $urandom;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
